// File: rtl/count32_timer_ctrl_pkg.sv
// Shared constants for the interval-timer controller: state encoding,
// reload modes and default datapath widths.
package count32_timer_ctrl_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_PS_W  = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/count32_timer_ctrl_core.sv
// Free-running counter datapath. clr wins over en; the count wraps
// modulo 2^WIDTH.
module count32_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count32_timer_ctrl.sv
// Interval-timer controller: command FSM, prescaler, period compare and
// reload policy around count32_core, plus expiry pulse and sticky irq.
module count32_timer_ctrl
  import count32_timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PS_W  = DEF_PS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] period_in,
  input  logic             mode_in,
  input  logic [PS_W-1:0]  prescale_in,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic             irq,
  output logic [1:0]       dbg_state
);

  state_t            state_q, state_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic [WIDTH-1:0]  period_q, period_d;
  logic              mode_q, mode_d;
  logic [PS_W-1:0]   prescale_q, prescale_d;
  logic              expired_q, expired_d;
  logic              irq_q, irq_d;

  logic              core_en;
  logic              core_clr;
  logic              irq_set;
  logic              idle_like;
  logic              tick;
  logic              match;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign tick      = (state_q == ST_RUN) && (ps_q == prescale_q);
  assign match     = (count == period_q);

  // Commands are mutually exclusive by priority; a pause cycle freezes the
  // datapath immediately, so no tick is taken in the cycle pause is accepted.
  always_comb begin
    state_d    = state_q;
    ps_d       = ps_q;
    period_d   = period_q;
    mode_d     = mode_q;
    prescale_d = prescale_q;
    expired_d  = 1'b0;
    irq_set    = 1'b0;
    core_en    = 1'b0;
    core_clr   = 1'b0;

    if (stop) begin
      state_d  = ST_IDLE;
      ps_d     = '0;
      core_clr = 1'b1;
    end else if (start && idle_like) begin
      state_d  = ST_RUN;
      ps_d     = '0;
      core_clr = 1'b1;
    end else if (start && (state_q == ST_PAUSE)) begin
      state_d = ST_RUN;
    end else if (pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSE;
    end else if (state_q == ST_RUN) begin
      ps_d = tick ? '0 : ps_q + 1'b1;
      if (tick) begin
        if (match) begin
          expired_d = 1'b1;
          irq_set   = 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            core_clr = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          core_en = 1'b1;
        end
      end
    end

    if (cfg_we && idle_like) begin
      period_d   = period_in;
      mode_d     = mode_in;
      prescale_d = prescale_in;
    end

    irq_d = irq_set | (irq_q & ~irq_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ps_q       <= '0;
      period_q   <= '1;
      mode_q     <= MODE_ONESHOT;
      prescale_q <= '0;
      expired_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      period_q   <= period_d;
      mode_q     <= mode_d;
      prescale_q <= prescale_d;
      expired_q  <= expired_d;
      irq_q      <= irq_d;
    end
  end

  count32_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .en   (core_en),
    .clr  (core_clr),
    .count(count)
  );

  assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign expired   = expired_q;
  assign irq       = irq_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_count32_timer_ctrl.sv
// Bench for count32_timer_ctrl: a 32-bit and a 4-bit instance share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_count32_timer_ctrl;
  import count32_timer_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, pause = 1'b0, stop = 1'b0, cfg_we = 1'b0;
  logic        mode_in = 1'b0, irq_clr = 1'b0;
  logic [31:0] period_in = '0;
  logic [7:0]  prescale_in = '0;

  always #5 clk = ~clk;

  logic [31:0] c32;
  logic        b32, e32, i32;
  logic [1:0]  s32;
  logic [3:0]  c4;
  logic        b4, e4, i4;
  logic [1:0]  s4;

  count32_timer_ctrl #(.WIDTH(32), .PS_W(8)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .cfg_we(cfg_we), .period_in(period_in), .mode_in(mode_in),
    .prescale_in(prescale_in), .irq_clr(irq_clr),
    .count(c32), .busy(b32), .expired(e32), .irq(i32), .dbg_state(s32)
  );

  count32_timer_ctrl #(.WIDTH(4), .PS_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .cfg_we(cfg_we), .period_in(period_in[3:0]), .mode_in(mode_in),
    .prescale_in(prescale_in), .irq_clr(irq_clr),
    .count(c4), .busy(b4), .expired(e4), .irq(i4), .dbg_state(s4)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  int unsigned msk [2] = '{32'hFFFF_FFFF, 32'h0000_000F};
  int          m_st [2];
  int unsigned m_cnt [2], m_ps [2], m_per [2], m_pre [2];
  bit          m_mode [2], m_exp [2], m_irq [2];

  always @(posedge clk or negedge rst) begin
    int          st;
    int unsigned cnt, ps;
    bit          ex, setv;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        m_st[d] <= M_IDLE; m_cnt[d] <= 0; m_ps[d] <= 0;
        m_per[d] <= msk[d]; m_pre[d] <= 0; m_mode[d] <= 0;
        m_exp[d] <= 0; m_irq[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        st = m_st[d]; cnt = m_cnt[d]; ps = m_ps[d]; ex = 0; setv = 0;
        if (stop) begin
          st = M_IDLE; cnt = 0; ps = 0;
        end else if (start && (st == M_IDLE || st == M_DONE)) begin
          st = M_RUN; cnt = 0; ps = 0;
        end else if (start && st == M_PAUSE) begin
          st = M_RUN;
        end else if (pause && st == M_RUN) begin
          st = M_PAUSE;
        end else if (st == M_RUN) begin
          if (ps == m_pre[d]) begin
            ps = 0;
            if (cnt == m_per[d]) begin
              ex = 1; setv = 1;
              if (m_mode[d]) cnt = 0;
              else st = M_DONE;
            end else begin
              cnt = (cnt + 1) & msk[d];
            end
          end else begin
            ps = ps + 1;
          end
        end
        if (cfg_we && (m_st[d] == M_IDLE || m_st[d] == M_DONE)) begin
          m_per[d]  <= period_in & msk[d];
          m_pre[d]  <= prescale_in;
          m_mode[d] <= mode_in;
        end
        m_st[d]  <= st;
        m_cnt[d] <= cnt;
        m_ps[d]  <= ps;
        m_exp[d] <= ex;
        m_irq[d] <= setv | (m_irq[d] & !irq_clr);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("m_count32",   c32, m_cnt[0]);
      check("m_busy32",    b32, (m_st[0] == M_RUN || m_st[0] == M_PAUSE));
      check("m_expired32", e32, m_exp[0]);
      check("m_irq32",     i32, m_irq[0]);
      check("m_count4",    c4,  m_cnt[1]);
      check("m_busy4",     b4,  (m_st[1] == M_RUN || m_st[1] == M_PAUSE));
      check("m_expired4",  e4,  m_exp[1]);
      check("m_irq4",      i4,  m_irq[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic pa, input logic sp,
                       input logic we, input logic ic);
    start = st; pause = pa; stop = sp; cfg_we = we; irq_clr = ic;
    @(negedge clk);
    start = 1'b0; pause = 1'b0; stop = 1'b0; cfg_we = 1'b0; irq_clr = 1'b0;
  endtask

  task automatic cfg(input logic [31:0] per, input logic [7:0] pre, input logic md);
    period_in = per; prescale_in = pre; mode_in = md;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_exp(input int sel, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((sel == 0) ? e32 : e4) && n < limit);
    check("exp_seen", (sel == 0) ? e32 : e4, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, total;

    #1;
    check("rst_count", c32, 0);
    check("rst_busy",  b32, 0);
    check("rst_exp",   e32, 0);
    check("rst_irq",   i32, 0);
    idle(2);
    rst = 1'b1;

    // one-shot, period 5, no prescale
    cfg(32'd5, 8'd0, MODE_ONESHOT);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("os_start_count", c32, 0);
    wait_exp(0, 50, n);
    check("os_latency", n, 6);
    check("os_hold",    c32, 5);
    check("os_busy",    b32, 0);
    check("os_irq",     i32, 1);
    check("os_state",   s32, ST_DONE);
    idle(1);
    check("os_pulse_end", e32, 0);

    // periodic, period 2, prescale 3
    cfg(32'd2, 8'd3, MODE_PERIODIC);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("irq_clr", i32, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_exp(0, 50, n);
    check("per_first", n, 12);
    check("per_reload", c32, 0);
    wait_exp(0, 50, n);
    check("per_second", n, 12);
    check("per_irq",  i32, 1);
    check("per_busy", b32, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stop_count", c32, 0);
    check("stop_busy",  b32, 0);
    check("stop_irq",   i32, 1);

    // period 0: every tick expires, count pinned at 0
    cfg(32'd0, 8'd1, MODE_PERIODIC);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_exp(0, 20, n);
    check("p0_first", n, 2);
    check("p0_count", c32, 0);
    wait_exp(0, 20, n);
    check("p0_second", n, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // pause/resume: ten frozen cycles delay expiry by ten
    cfg(32'd6, 8'd0, MODE_ONESHOT);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_exp(0, 50, n);
    check("ref_latency", n, 7);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("pr_at3", c32, 3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pr_frozen", c32, 3);
    check("pr_busy",   b32, 1);
    idle(8);
    check("pr_held", c32, 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pr_resume", c32, 3);
    wait_exp(0, 50, n);
    total = 3 + 1 + 8 + 1 + n;
    check("pr_delay", total, 7 + 10);

    // stop beats start; cfg ignored while running
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("prio_count", c32, 0);
    check("prio_busy",  b32, 0);
    check("prio_state", s32, ST_IDLE);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    period_in = 32'd9;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_exp(0, 50, n);
    check("lock_latency", n, 5);
    check("lock_count",   c32, 6);

    // wrap at all-ones on the 4-bit instance, irq_clr racing a set
    cfg(32'hFFFF_FFFF, 8'd0, MODE_PERIODIC);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("wrap_irq_pre", i4, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(15);
    check("wrap_max", c4, 15);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("wrap_exp",   e4, 1);
    check("wrap_zero",  c4, 0);
    check("wrap_race",  i4, 1);
    check("wrap_busy",  b4, 1);
    check("wide_count", c32, 16);
    idle(1);
    check("wrap_pulse_end", e4, 0);

    // asynchronous reset mid-count
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(32'h1234);
    check("mid_count", c32, 32'h1234);
    rst = 1'b0;
    #1;
    check("arst_count", c32, 0);
    check("arst_busy",  b32, 0);
    check("arst_exp",   e32, 0);
    check("arst_irq4",  i4,  0);
    check("arst_cnt4",  c4,  0);
    idle(2);
    rst = 1'b1;
    idle(1);
    check("post_state", s32, ST_IDLE);
    check("post_busy",  b32, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("post_cfg_prescale", c32, 1);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
